// File: rtl/max7219_rx_pkg.sv
// Shared types, register addresses and register-file access helpers
// for the MAX7219 serial receiver.
package max7219_rx_pkg;

  localparam logic [3:0] C_ADDR_NOOP       = 4'h0;
  localparam logic [3:0] C_ADDR_DIGIT0     = 4'h1;
  localparam logic [3:0] C_ADDR_DIGIT1     = 4'h2;
  localparam logic [3:0] C_ADDR_DIGIT2     = 4'h3;
  localparam logic [3:0] C_ADDR_DIGIT3     = 4'h4;
  localparam logic [3:0] C_ADDR_DIGIT4     = 4'h5;
  localparam logic [3:0] C_ADDR_DIGIT5     = 4'h6;
  localparam logic [3:0] C_ADDR_DIGIT6     = 4'h7;
  localparam logic [3:0] C_ADDR_DIGIT7     = 4'h8;
  localparam logic [3:0] C_ADDR_DECODE     = 4'h9;
  localparam logic [3:0] C_ADDR_INTENSITY  = 4'hA;
  localparam logic [3:0] C_ADDR_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] C_ADDR_SHUTDOWN   = 4'hC;
  localparam logic [3:0] C_ADDR_TEST       = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } t_rx_state;

  typedef struct packed {
    logic [7:0][7:0] digit;
    logic [7:0]      decode;
    logic [3:0]      intensity;
    logic [2:0]      scan;
    logic            shutdown;
    logic            test;
  } t_max7219_regs;

  // Apply one 16-bit MAX7219 word to a device register set; word[15:12] is ignored.
  function automatic t_max7219_regs reg_write(input t_max7219_regs r, input logic [15:0] word);
    t_max7219_regs nr;
    logic [3:0]    addr;
    logic [7:0]    data;
    logic [3:0]    idx;
    nr   = r;
    addr = word[11:8];
    data = word[7:0];
    idx  = addr - C_ADDR_DIGIT0;
    case (addr)
      C_ADDR_DIGIT0, C_ADDR_DIGIT1, C_ADDR_DIGIT2, C_ADDR_DIGIT3,
      C_ADDR_DIGIT4, C_ADDR_DIGIT5, C_ADDR_DIGIT6, C_ADDR_DIGIT7:
        nr.digit[idx[2:0]] = data;
      C_ADDR_DECODE:     nr.decode    = data;
      C_ADDR_INTENSITY:  nr.intensity = data[3:0];
      C_ADDR_SCAN_LIMIT: nr.scan      = data[2:0];
      C_ADDR_SHUTDOWN:   nr.shutdown  = data[0];
      C_ADDR_TEST:       nr.test      = data[0];
      default: ;
    endcase
    return nr;
  endfunction

  // Read one register, zero-extending narrow fields; unmapped addresses read 0.
  function automatic logic [7:0] reg_read(input t_max7219_regs r, input logic [3:0] addr);
    logic [7:0] val;
    logic [3:0] idx;
    idx = addr - C_ADDR_DIGIT0;
    case (addr)
      C_ADDR_DIGIT0, C_ADDR_DIGIT1, C_ADDR_DIGIT2, C_ADDR_DIGIT3,
      C_ADDR_DIGIT4, C_ADDR_DIGIT5, C_ADDR_DIGIT6, C_ADDR_DIGIT7:
        val = r.digit[idx[2:0]];
      C_ADDR_DECODE:     val = r.decode;
      C_ADDR_INTENSITY:  val = {4'b0, r.intensity};
      C_ADDR_SCAN_LIMIT: val = {5'b0, r.scan};
      C_ADDR_SHUTDOWN:   val = {7'b0, r.shutdown};
      C_ADDR_TEST:       val = {7'b0, r.test};
      default:           val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/max7219_rx_if.sv
// MAX7219 3-wire serial link (LOAD/DIN/CLK).
interface max7219_rx_if;
  logic max7219_clk;
  logic max7219_din;
  logic max7219_load;

  modport master (
    output max7219_clk,
    output max7219_din,
    output max7219_load
  );

  modport slave (
    input max7219_clk,
    input max7219_din,
    input max7219_load
  );
endinterface

// File: rtl/max7219_rx_edge_sync.sv
// Optional multi-flop synchroniser followed by a one-flop rise/fall detector.
module max7219_rx_edge_sync #(
  parameter int unsigned G_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic sig_d;

  generate
    if (G_SYNC_STAGES == 0) begin : g_nosync
      assign o_sync = i_sig;
    end else begin : g_sync
      logic [G_SYNC_STAGES-1:0] chain;

      // Synchroniser chain, chain[0] samples the asynchronous input
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain <= '0;
        end else begin
          chain[0] <= i_sig;
          for (int unsigned i = 1; i < G_SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign o_sync = chain[G_SYNC_STAGES-1];
    end
  endgenerate

  // Previous synchronised value for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_d <= 1'b0;
    end else begin
      sig_d <= o_sync;
    end
  end

  assign o_rise = o_sync & ~sig_d;
  assign o_fall = ~o_sync & sig_d;

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 daisy-chain receiver: deserialises 16*G_NB_MATRIX-bit frames and
// latches them into a per-device register file on the LOAD rising edge.
module max7219_rx
  import max7219_rx_pkg::*;
#(
  parameter int unsigned G_NB_MATRIX   = 8,
  parameter int unsigned G_SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  max7219_rx_if.slave        link,
  input  logic [3:0]         i_rd_matrix,
  input  logic [3:0]         i_rd_addr,
  output logic [7:0]         o_rd_data,
  output logic               o_frame_valid,
  output logic               o_len_err,
  output logic               o_busy,
  output logic [15:0]        o_frame_cnt
);

  localparam int unsigned C_W       = 16 * G_NB_MATRIX;
  localparam int unsigned C_CNT_MAX = C_W + 1;
  localparam int unsigned C_CNT_W   = $clog2(C_W + 2);

  t_rx_state            state;
  logic [C_W-1:0]       sreg;
  logic [C_CNT_W-1:0]   bit_cnt;
  t_max7219_regs        regs [G_NB_MATRIX];
  logic [7:0]           rd_mux;

  logic clk_sync, clk_rise, clk_fall;
  logic din_sync, din_rise, din_fall;
  logic load_sync, load_rise, load_fall;
  logic unused_edges;

  max7219_rx_edge_sync #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_clk (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (link.max7219_clk),
    .o_sync (clk_sync),
    .o_rise (clk_rise),
    .o_fall (clk_fall)
  );

  max7219_rx_edge_sync #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_din (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (link.max7219_din),
    .o_sync (din_sync),
    .o_rise (din_rise),
    .o_fall (din_fall)
  );

  max7219_rx_edge_sync #(.G_SYNC_STAGES(G_SYNC_STAGES)) u_sync_load (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (link.max7219_load),
    .o_sync (load_sync),
    .o_rise (load_rise),
    .o_fall (load_fall)
  );

  assign unused_edges = ^{clk_sync, clk_fall, din_rise, din_fall, load_sync};

  // Frame FSM with shift register, bit counter and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      sreg          <= '0;
      bit_cnt       <= '0;
      o_frame_valid <= 1'b0;
      o_len_err     <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_frame_valid <= 1'b0;
      o_len_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_fall) begin
            state   <= S_SHIFT;
            bit_cnt <= '0;
            o_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          // A CLK edge seen together with the LOAD rise is still shifted in
          if (clk_rise) begin
            sreg <= {sreg[C_W-2:0], din_sync};
            if (bit_cnt != C_CNT_W'(C_CNT_MAX)) begin
              bit_cnt <= bit_cnt + C_CNT_W'(1);
            end
          end
          if (load_rise) begin
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          o_frame_valid <= (bit_cnt >= C_CNT_W'(16));
          o_len_err     <= (bit_cnt != C_CNT_W'(C_W));
          o_frame_cnt   <= o_frame_cnt + 16'd1;
          o_busy        <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file update: the word shifted last lands in matrix 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < G_NB_MATRIX; k++) begin
        regs[k] <= '0;
      end
    end else if (state == S_LATCH && bit_cnt >= C_CNT_W'(16)) begin
      for (int unsigned k = 0; k < G_NB_MATRIX; k++) begin
        regs[k] <= reg_write(regs[k], sreg[16*k +: 16]);
      end
    end
  end

  // Read mux; out-of-range matrix indices fall through to 0
  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < G_NB_MATRIX; k++) begin
      if (i_rd_matrix == 4'(k)) begin
        rd_mux = reg_read(regs[k], i_rd_addr);
      end
    end
  end

  // Registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= rd_mux;
    end
  end

endmodule
